// File: rtl/r88_regfile_pkg.sv
// Shared constants for the Rocket88 register file: select offsets, SP operations,
// FLAGS bit positions and address-source codes.
package r88_regfile_pkg;

   // Offsets of the fixed registers, counted from the first select after the GPRs
   localparam int SEL_DDLO      = 0;
   localparam int SEL_DDHI      = 1;
   localparam int SEL_EELO      = 2;
   localparam int SEL_EEHI      = 3;
   localparam int SEL_PCLO      = 4;
   localparam int SEL_PCHI      = 5;
   localparam int SEL_SPLO      = 6;
   localparam int SEL_SPHI      = 7;
   localparam int SEL_FLAGS     = 8;
   localparam int SEL_NUM_FIXED = 9;

   localparam logic [1:0] SPOP_NONE = 2'd0;
   localparam logic [1:0] SPOP_PUSH = 2'd1;
   localparam logic [1:0] SPOP_POP  = 2'd2;

   localparam int FLAG_S = 7;
   localparam int FLAG_Z = 6;
   localparam int FLAG_C = 5;
   localparam int FLAG_I = 4;
   localparam int FLAG_D = 3;
   localparam int FLAG_B = 2;

   localparam logic [1:0] ADDRSEL_BC = 2'd0;
   localparam logic [1:0] ADDRSEL_DD = 2'd1;
   localparam logic [1:0] ADDRSEL_PC = 2'd2;
   localparam logic [1:0] ADDRSEL_SP = 2'd3;

   function automatic int sel_width(input int num_gpr);
      return $clog2(num_gpr + SEL_NUM_FIXED);
   endfunction

endpackage

// File: rtl/r88_regfile_if.sv
// Register-file bus bundle: the master drives the controls, the slave is the register file.
interface r88_regfile_if
   import r88_regfile_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int NUM_GPR = 3
);
   localparam int SEL_W = sel_width(NUM_GPR);

   logic [DATA_W-1:0]   intDIn;
   logic [DATA_W-1:0]   intDOut;
   logic                intDOutEn;
   logic [SEL_W-1:0]    regSel;
   logic                regRead;
   logic                regWrite;
   logic [2:0]          regRightSel;
   logic [2:0]          regLeftSel;
   logic [1:0]          regAddrSel;
   logic [DATA_W-1:0]   regRight;
   logic [DATA_W-1:0]   regLeft;
   logic [2*DATA_W-1:0] regAddr;
   logic                pcInc;
   logic [1:0]          spOp;
   logic [DATA_W-1:0]   flagsIn;
   logic                flagsWe;
   logic [DATA_W-1:0]   flags;
   logic                bankSwap;
   logic                activeBank;

   modport master (
      output intDIn, regSel, regRead, regWrite, regRightSel, regLeftSel, regAddrSel,
             pcInc, spOp, flagsIn, flagsWe, bankSwap,
      input  intDOut, intDOutEn, regRight, regLeft, regAddr, flags, activeBank
   );

   modport slave (
      input  intDIn, regSel, regRead, regWrite, regRightSel, regLeftSel, regAddrSel,
             pcInc, spOp, flagsIn, flagsWe, bankSwap,
      output intDOut, intDOutEn, regRight, regLeft, regAddr, flags, activeBank
   );

endinterface

// File: rtl/r88_regfile_addr_counter.sv
// Loadable 2*W-bit up/down counter used for PC and SP. A byte load in a cycle
// suppresses any increment/decrement; increment wins over decrement.
module r88_addr_counter #(
   parameter int               W         = 8,
   parameter logic [2*W-1:0]   RESET_VAL = '0
) (
   input  logic           clk_i,
   input  logic           rst_n_i,
   input  logic           ld_lo_i,
   input  logic           ld_hi_i,
   input  logic [W-1:0]   din_i,
   input  logic           inc_i,
   input  logic           dec_i,
   output logic [2*W-1:0] cnt_o
);
   localparam int             CW  = 2 * W;
   localparam logic [CW-1:0]  ONE = {{(CW-1){1'b0}}, 1'b1};

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: byte loads first, then inc/dec with natural wrap
   always_comb begin
      cnt_d = cnt_q;
      if (ld_lo_i || ld_hi_i) begin
         cnt_d[W-1:0]  = ld_lo_i ? din_i : cnt_q[W-1:0];
         cnt_d[CW-1:W] = ld_hi_i ? din_i : cnt_q[CW-1:W];
      end else if (inc_i) begin
         cnt_d = cnt_q + ONE;
      end else if (dec_i) begin
         cnt_d = cnt_q - ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= RESET_VAL;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/r88_regfile.sv
// Rocket88 register file: GPRs, DD/EE pairs, PC/SP counters and FLAGS with registered
// read, operand and address ports. Macro R88_SHADOW_BANK_EN adds a swappable GPR/FLAGS bank.
module r88_regfile
   import r88_regfile_pkg::*;
#(
   parameter int                  DATA_W   = 8,
   parameter int                  NUM_GPR  = 3,
   parameter logic [2*DATA_W-1:0] PC_RESET = '0,
   parameter logic [2*DATA_W-1:0] SP_RESET = '1
) (
   input  logic          sysClock,
   input  logic          sysResetN,
   r88_regfile_if.slave  bus
);
   localparam int SEL_W = sel_width(NUM_GPR);
   localparam int AW    = 2 * DATA_W;

   localparam logic [SEL_W-1:0] S_DDLO  = SEL_W'(NUM_GPR + SEL_DDLO);
   localparam logic [SEL_W-1:0] S_DDHI  = SEL_W'(NUM_GPR + SEL_DDHI);
   localparam logic [SEL_W-1:0] S_EELO  = SEL_W'(NUM_GPR + SEL_EELO);
   localparam logic [SEL_W-1:0] S_EEHI  = SEL_W'(NUM_GPR + SEL_EEHI);
   localparam logic [SEL_W-1:0] S_PCLO  = SEL_W'(NUM_GPR + SEL_PCLO);
   localparam logic [SEL_W-1:0] S_PCHI  = SEL_W'(NUM_GPR + SEL_PCHI);
   localparam logic [SEL_W-1:0] S_SPLO  = SEL_W'(NUM_GPR + SEL_SPLO);
   localparam logic [SEL_W-1:0] S_SPHI  = SEL_W'(NUM_GPR + SEL_SPHI);
   localparam logic [SEL_W-1:0] S_FLAGS = SEL_W'(NUM_GPR + SEL_FLAGS);

   logic [DATA_W-1:0] gpr_q [NUM_GPR];
   logic [DATA_W-1:0] gpr_d [NUM_GPR];
   logic [DATA_W-1:0] flags_q, flags_d;
   logic [AW-1:0]     dd_q, dd_d, ee_q, ee_d;
   logic [AW-1:0]     pc_s, sp_s;
   logic [DATA_W-1:0] dout_q, dout_d, rd_s;
   logic              douten_q;
   logic [DATA_W-1:0] right_q, right_d, left_q, left_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic              wr_s;

   // A simultaneous read suppresses the write
   assign wr_s = bus.regWrite & ~bus.regRead;

   // Write-side next state for GPRs, DD, EE and FLAGS
   always_comb begin
      for (int i = 0; i < NUM_GPR; i++) begin
         gpr_d[i] = (wr_s && bus.regSel == SEL_W'(i)) ? bus.intDIn : gpr_q[i];
      end
      dd_d = {(wr_s && bus.regSel == S_DDHI) ? bus.intDIn : dd_q[AW-1:DATA_W],
              (wr_s && bus.regSel == S_DDLO) ? bus.intDIn : dd_q[DATA_W-1:0]};
      ee_d = {(wr_s && bus.regSel == S_EEHI) ? bus.intDIn : ee_q[AW-1:DATA_W],
              (wr_s && bus.regSel == S_EELO) ? bus.intDIn : ee_q[DATA_W-1:0]};
      if (wr_s && bus.regSel == S_FLAGS) begin
         flags_d = {bus.intDIn[DATA_W-1:FLAG_B], {FLAG_B{1'b0}}};
      end else if (bus.flagsWe) begin
         flags_d = bus.flagsIn;
      end else begin
         flags_d = flags_q;
      end
   end

   r88_addr_counter #(.W(DATA_W), .RESET_VAL(PC_RESET)) u_pc (
      .clk_i   (sysClock),
      .rst_n_i (sysResetN),
      .ld_lo_i (wr_s && bus.regSel == S_PCLO),
      .ld_hi_i (wr_s && bus.regSel == S_PCHI),
      .din_i   (bus.intDIn),
      .inc_i   (bus.pcInc),
      .dec_i   (1'b0),
      .cnt_o   (pc_s)
   );

   r88_addr_counter #(.W(DATA_W), .RESET_VAL(SP_RESET)) u_sp (
      .clk_i   (sysClock),
      .rst_n_i (sysResetN),
      .ld_lo_i (wr_s && bus.regSel == S_SPLO),
      .ld_hi_i (wr_s && bus.regSel == S_SPHI),
      .din_i   (bus.intDIn),
      .inc_i   (bus.spOp == SPOP_POP),
      .dec_i   (bus.spOp == SPOP_PUSH),
      .cnt_o   (sp_s)
   );

   // Read-side muxes: all outputs reflect pre-edge contents, no write bypass
   always_comb begin
      case (bus.regSel)
         S_DDLO:  rd_s = dd_q[DATA_W-1:0];
         S_DDHI:  rd_s = dd_q[AW-1:DATA_W];
         S_EELO:  rd_s = ee_q[DATA_W-1:0];
         S_EEHI:  rd_s = ee_q[AW-1:DATA_W];
         S_PCLO:  rd_s = pc_s[DATA_W-1:0];
         S_PCHI:  rd_s = pc_s[AW-1:DATA_W];
         S_SPLO:  rd_s = sp_s[DATA_W-1:0];
         S_SPHI:  rd_s = sp_s[AW-1:DATA_W];
         S_FLAGS: rd_s = flags_q;
         default: begin
            rd_s = '0;
            for (int i = 0; i < NUM_GPR; i++) begin
               rd_s = (bus.regSel == SEL_W'(i)) ? gpr_q[i] : rd_s;
            end
         end
      endcase
      dout_d  = bus.regRead ? rd_s : dout_q;
      right_d = '0;
      left_d  = '0;
      for (int i = 0; i < NUM_GPR; i++) begin
         right_d = (bus.regRightSel == 3'(i)) ? gpr_q[i] : right_d;
         left_d  = (bus.regLeftSel  == 3'(i)) ? gpr_q[i] : left_d;
      end
      case (bus.regAddrSel)
         ADDRSEL_BC: addr_d = {gpr_q[1], gpr_q[2]};
         ADDRSEL_DD: addr_d = dd_q;
         ADDRSEL_PC: addr_d = pc_s;
         ADDRSEL_SP: addr_d = sp_s;
         default:    addr_d = {gpr_q[1], gpr_q[2]};
      endcase
   end

   // Unbanked pairs and registered output ports
   always_ff @(posedge sysClock or negedge sysResetN) begin
      if (!sysResetN) begin
         dd_q     <= '0;
         ee_q     <= '0;
         dout_q   <= '0;
         douten_q <= 1'b0;
         right_q  <= '0;
         left_q   <= '0;
         addr_q   <= '0;
      end else begin
         dd_q     <= dd_d;
         ee_q     <= ee_d;
         dout_q   <= dout_d;
         douten_q <= bus.regRead;
         right_q  <= right_d;
         left_q   <= left_d;
         addr_q   <= addr_d;
      end
   end

`ifdef R88_SHADOW_BANK_EN
   logic [DATA_W-1:0] gpr_sh_q [NUM_GPR];
   logic [DATA_W-1:0] flags_sh_q;
   logic              bank_q;

   // A swap exchanges working and shadow sets; this cycle's write goes to the outgoing set
   always_ff @(posedge sysClock or negedge sysResetN) begin
      if (!sysResetN) begin
         gpr_q      <= '{default: '0};
         gpr_sh_q   <= '{default: '0};
         flags_q    <= '0;
         flags_sh_q <= '0;
         bank_q     <= 1'b0;
      end else if (bus.bankSwap) begin
         gpr_q      <= gpr_sh_q;
         gpr_sh_q   <= gpr_d;
         flags_q    <= flags_sh_q;
         flags_sh_q <= flags_d;
         bank_q     <= ~bank_q;
      end else begin
         gpr_q      <= gpr_d;
         flags_q    <= flags_d;
      end
   end

   assign bus.activeBank = bank_q;
`else
   logic unused_swap_s;
   assign unused_swap_s = bus.bankSwap;

   // Single GPR/FLAGS bank
   always_ff @(posedge sysClock or negedge sysResetN) begin
      if (!sysResetN) begin
         gpr_q   <= '{default: '0};
         flags_q <= '0;
      end else begin
         gpr_q   <= gpr_d;
         flags_q <= flags_d;
      end
   end

   assign bus.activeBank = 1'b0;
`endif

   assign bus.intDOut   = dout_q;
   assign bus.intDOutEn = douten_q;
   assign bus.regRight  = right_q;
   assign bus.regLeft   = left_q;
   assign bus.regAddr   = addr_q;
   assign bus.flags     = flags_q;

endmodule

// File: tb/tb_r88_regfile.sv
// Self-checking bench for r88_regfile: directed vector table, corner sequences and
// randomized traffic against an array-based reference model. Honours R88_SHADOW_BANK_EN.
module tb_r88_regfile;
   localparam int DATA_W  = 8;
   localparam int NUM_GPR = 3;
`ifdef R88_SHADOW_BANK_EN
   localparam bit SHADOW = 1'b1;
`else
   localparam bit SHADOW = 1'b0;
`endif

   localparam int K_NONE = 0, K_DOUT = 1, K_ADDR = 2, K_LEFT = 3, K_RIGHT = 4, K_FLAGS = 5, K_NOEN = 6;

   typedef struct {
      bit rd; bit wr; int sel; int din; bit pci; int spop; bit fwe; int fin;
      int osel; int asel; int kind; int exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   r88_regfile_if #(.DATA_W(DATA_W), .NUM_GPR(NUM_GPR)) bus ();

   r88_regfile #(.DATA_W(DATA_W), .NUM_GPR(NUM_GPR), .PC_RESET(16'h0000), .SP_RESET(16'hFFFF)) dut (
      .sysClock  (clk),
      .sysResetN (rst_n),
      .bus       (bus)
   );

   // Reference model state
   int m_gpr [2][8];
   int m_flags [2];
   int m_dd, m_ee, m_pc, m_sp, m_bank;
   int m_dout, m_right, m_left, m_addr;
   bit m_en;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < 8; i++) m_gpr[b][i] = 0;
         m_flags[b] = 0;
      end
      m_dd = 0; m_ee = 0; m_pc = 0; m_sp = 'hFFFF; m_bank = 0;
      m_dout = 0; m_en = 0; m_right = 0; m_left = 0; m_addr = 0;
   endtask

   function automatic int m_read(input int sel);
      if (sel < NUM_GPR) return m_gpr[m_bank][sel];
      case (sel - NUM_GPR)
         0: return m_dd & 'hFF;
         1: return m_dd >> 8;
         2: return m_ee & 'hFF;
         3: return m_ee >> 8;
         4: return m_pc & 'hFF;
         5: return m_pc >> 8;
         6: return m_sp & 'hFF;
         7: return m_sp >> 8;
         8: return m_flags[m_bank];
         default: return 0;
      endcase
   endfunction

   function automatic int set_byte(input int word, input bit hi, input int b);
      return hi ? ((word & 'h00FF) | (b << 8)) : ((word & 'hFF00) | b);
   endfunction

   // Predict outputs for the coming edge from current state, then advance state
   task automatic model_step();
      int sel, din, rs, ls;
      bit wr, pc_w, sp_w, fl_w;
      sel = int'(bus.regSel); din = int'(bus.intDIn);
      rs = int'(bus.regRightSel); ls = int'(bus.regLeftSel);
      wr = bus.regWrite && !bus.regRead;
      pc_w = 0; sp_w = 0; fl_w = 0;
      if (bus.regRead) m_dout = m_read(sel);
      m_en    = bus.regRead;
      m_right = (rs < NUM_GPR) ? m_gpr[m_bank][rs] : 0;
      m_left  = (ls < NUM_GPR) ? m_gpr[m_bank][ls] : 0;
      case (int'(bus.regAddrSel))
         0: m_addr = (m_gpr[m_bank][1] << 8) | m_gpr[m_bank][2];
         1: m_addr = m_dd;
         2: m_addr = m_pc;
         default: m_addr = m_sp;
      endcase
      if (wr) begin
         if (sel < NUM_GPR) m_gpr[m_bank][sel] = din;
         else case (sel - NUM_GPR)
            0, 1: m_dd = set_byte(m_dd, (sel - NUM_GPR) == 1, din);
            2, 3: m_ee = set_byte(m_ee, (sel - NUM_GPR) == 3, din);
            4, 5: begin m_pc = set_byte(m_pc, (sel - NUM_GPR) == 5, din); pc_w = 1; end
            6, 7: begin m_sp = set_byte(m_sp, (sel - NUM_GPR) == 7, din); sp_w = 1; end
            8:    begin m_flags[m_bank] = din & 'hFC; fl_w = 1; end
            default: ;
         endcase
      end
      if (!pc_w && bus.pcInc) m_pc = (m_pc + 1) % 65536;
      if (!sp_w && bus.spOp == 2'd1) m_sp = (m_sp + 65535) % 65536;
      if (!sp_w && bus.spOp == 2'd2) m_sp = (m_sp + 1) % 65536;
      if (!fl_w && bus.flagsWe) m_flags[m_bank] = int'(bus.flagsIn);
      if (SHADOW && bus.bankSwap) m_bank = 1 - m_bank;
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      chk("intDOutEn", int'(bus.intDOutEn), int'(m_en));
      if (m_en) chk("intDOut", int'(bus.intDOut), m_dout);
      chk("regRight", int'(bus.regRight), m_right);
      chk("regLeft", int'(bus.regLeft), m_left);
      chk("regAddr", int'(bus.regAddr), m_addr);
      chk("flags", int'(bus.flags), m_flags[m_bank]);
      chk("activeBank", int'(bus.activeBank), m_bank);
   endtask

   task automatic drive(input bit rd, input bit wr, input int sel, input int din);
      bus.regRead = rd; bus.regWrite = wr; bus.regSel = 4'(sel); bus.intDIn = 8'(din);
      bus.pcInc = 1'b0; bus.spOp = 2'd0; bus.flagsWe = 1'b0; bus.flagsIn = 8'h00;
      bus.bankSwap = 1'b0; bus.regLeftSel = 3'd0; bus.regRightSel = 3'd0; bus.regAddrSel = 2'd0;
   endtask

   function automatic vec_t mk(input bit rd, input bit wr, input int sel, input int din, input bit pci,
                               input int spop, input bit fwe, input int fin, input int osel,
                               input int asel, input int kind, input int exp);
      vec_t v;
      v.rd = rd; v.wr = wr; v.sel = sel; v.din = din; v.pci = pci; v.spop = spop; v.fwe = fwe;
      v.fin = fin; v.osel = osel; v.asel = asel; v.kind = kind; v.exp = exp;
      return v;
   endfunction

   vec_t vecs[$];

   initial begin
      vecs.push_back(mk(1,0, 8,'h00,0,0,0,'h00,0,0,K_DOUT ,'h00));
      vecs.push_back(mk(1,0, 7,'h00,0,0,0,'h00,0,0,K_DOUT ,'h00));
      vecs.push_back(mk(1,0, 9,'h00,0,0,0,'h00,0,0,K_DOUT ,'hFF));
      vecs.push_back(mk(0,1, 0,'h5A,0,0,0,'h00,0,0,K_NONE ,0));
      vecs.push_back(mk(0,1, 1,'h12,0,0,0,'h00,0,0,K_NONE ,0));
      vecs.push_back(mk(0,1, 2,'h34,0,0,0,'h00,0,0,K_NONE ,0));
      vecs.push_back(mk(0,0, 0,'h00,0,0,0,'h00,0,0,K_ADDR ,'h1234));
      vecs.push_back(mk(0,0, 0,'h00,0,0,0,'h00,0,0,K_LEFT ,'h5A));
      vecs.push_back(mk(0,1, 7,'hFF,0,0,0,'h00,0,0,K_NONE ,0));
      vecs.push_back(mk(0,1, 8,'hFF,0,0,0,'h00,0,0,K_NONE ,0));
      vecs.push_back(mk(0,0, 0,'h00,1,0,0,'h00,0,2,K_ADDR ,'hFFFF));
      vecs.push_back(mk(0,0, 0,'h00,0,0,0,'h00,0,2,K_ADDR ,'h0000));
      vecs.push_back(mk(0,1, 7,'hFF,0,0,0,'h00,0,0,K_NONE ,0));
      vecs.push_back(mk(0,1, 8,'hFF,0,0,0,'h00,0,0,K_NONE ,0));
      vecs.push_back(mk(0,1, 7,'h77,1,0,0,'h00,0,2,K_ADDR ,'hFFFF));
      vecs.push_back(mk(0,0, 0,'h00,0,0,0,'h00,0,2,K_ADDR ,'hFF77));
      vecs.push_back(mk(0,1, 9,'h00,0,0,0,'h00,0,0,K_NONE ,0));
      vecs.push_back(mk(0,1,10,'h00,0,0,0,'h00,0,0,K_NONE ,0));
      vecs.push_back(mk(0,0, 0,'h00,0,1,0,'h00,0,3,K_ADDR ,'h0000));
      vecs.push_back(mk(0,0, 0,'h00,0,2,0,'h00,0,3,K_ADDR ,'hFFFF));
      vecs.push_back(mk(0,1,10,'h80,0,1,0,'h00,0,3,K_ADDR ,'h0000));
      vecs.push_back(mk(0,0, 0,'h00,0,0,0,'h00,0,3,K_ADDR ,'h8000));
      vecs.push_back(mk(0,1,11,'hFF,0,0,1,'h00,0,0,K_FLAGS,'hFC));
      vecs.push_back(mk(0,0, 0,'h00,0,0,1,'h03,0,0,K_FLAGS,'h03));
      vecs.push_back(mk(1,1, 0,'h99,0,0,0,'h00,0,0,K_DOUT ,'h5A));
      vecs.push_back(mk(1,0, 0,'h00,0,0,0,'h00,0,0,K_DOUT ,'h5A));
      vecs.push_back(mk(1,0,15,'h00,0,0,0,'h00,0,0,K_DOUT ,'h00));
      vecs.push_back(mk(0,0, 0,'h00,0,0,0,'h00,7,0,K_RIGHT,'h00));
      vecs.push_back(mk(0,0, 0,'h00,0,0,0,'h00,0,0,K_NOEN ,0));

      // Reset state
      drive(1'b0, 1'b0, 0, 0);
      model_reset();
      #12;
      chk("rst_douten", int'(bus.intDOutEn), 0);
      chk("rst_dout", int'(bus.intDOut), 0);
      chk("rst_addr", int'(bus.regAddr), 0);
      chk("rst_left", int'(bus.regLeft), 0);
      chk("rst_flags", int'(bus.flags), 0);
      chk("rst_bank", int'(bus.activeBank), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vector table
      foreach (vecs[n]) begin
         drive(vecs[n].rd, vecs[n].wr, vecs[n].sel, vecs[n].din);
         bus.pcInc = vecs[n].pci; bus.spOp = 2'(vecs[n].spop);
         bus.flagsWe = vecs[n].fwe; bus.flagsIn = 8'(vecs[n].fin);
         bus.regLeftSel = 3'(vecs[n].osel); bus.regRightSel = 3'(vecs[n].osel);
         bus.regAddrSel = 2'(vecs[n].asel);
         cycle();
         case (vecs[n].kind)
            K_DOUT: begin
               chk($sformatf("vec%0d_en", n), int'(bus.intDOutEn), 1);
               chk($sformatf("vec%0d_dout", n), int'(bus.intDOut), vecs[n].exp);
            end
            K_ADDR:  chk($sformatf("vec%0d_addr", n), int'(bus.regAddr), vecs[n].exp);
            K_LEFT:  chk($sformatf("vec%0d_left", n), int'(bus.regLeft), vecs[n].exp);
            K_RIGHT: chk($sformatf("vec%0d_right", n), int'(bus.regRight), vecs[n].exp);
            K_FLAGS: chk($sformatf("vec%0d_flags", n), int'(bus.flags), vecs[n].exp);
            K_NOEN:  chk($sformatf("vec%0d_noen", n), int'(bus.intDOutEn), 0);
            default: ;
         endcase
      end

      // Bank swap sequence (A currently holds 5A)
      if (SHADOW) begin
         drive(1'b0, 1'b1, 0, 'h11); cycle();
         drive(1'b0, 1'b0, 0, 0); bus.bankSwap = 1'b1; cycle();
         chk("swap_bank1", int'(bus.activeBank), 1);
         drive(1'b1, 1'b0, 0, 0); cycle();
         chk("swap_rd_new", int'(bus.intDOut), 'h00);
         drive(1'b0, 1'b1, 0, 'h22); cycle();
         drive(1'b0, 1'b0, 0, 0); bus.bankSwap = 1'b1; cycle();
         drive(1'b1, 1'b0, 0, 0); cycle();
         chk("swap_rd_old", int'(bus.intDOut), 'h11);
         chk("swap_bank0", int'(bus.activeBank), 0);
      end else begin
         drive(1'b0, 1'b0, 0, 0); bus.bankSwap = 1'b1; cycle();
         chk("noswap_bank", int'(bus.activeBank), 0);
         drive(1'b1, 1'b0, 0, 0); cycle();
         chk("noswap_rd", int'(bus.intDOut), 'h5A);
      end

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 15),
               $urandom_range(0, 255));
         bus.pcInc = 1'($urandom_range(0, 1));
         bus.spOp = 2'($urandom_range(0, 3));
         bus.flagsWe = ($urandom_range(0, 3) == 0);
         bus.flagsIn = 8'($urandom_range(0, 255));
         bus.bankSwap = ($urandom_range(0, 7) == 0);
         bus.regLeftSel = 3'($urandom_range(0, 7));
         bus.regRightSel = 3'($urandom_range(0, 7));
         bus.regAddrSel = 2'($urandom_range(0, 3));
         cycle();
      end

      // Asynchronous reset in the middle of activity
      drive(1'b1, 1'b0, 0, 0); bus.pcInc = 1'b1; bus.regAddrSel = 2'd2;
      cycle();
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_douten", int'(bus.intDOutEn), 0);
      chk("arst_addr", int'(bus.regAddr), 0);
      chk("arst_flags", int'(bus.flags), 0);
      chk("arst_left", int'(bus.regLeft), 0);
      chk("arst_bank", int'(bus.activeBank), 0);
      model_reset();
      @(negedge clk);
      drive(1'b1, 1'b0, 9, 0); bus.regAddrSel = 2'd2;
      rst_n = 1'b1;
      cycle();
      chk("arst_first_en", int'(bus.intDOutEn), 1);
      chk("arst_first_sp", int'(bus.intDOut), 'hFF);
      chk("arst_pc", int'(bus.regAddr), 'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
